// File: rtl/inta_sequencer.sv
// 8086-style interrupt acknowledge sequencer: two INTA pulses, vector capture, valid/ack handoff.
// Optional build macro INTA_SPURIOUS_EN runs the full cycle even if INT dropped before confirmation.
module inta_sequencer #(
    parameter int unsigned PULSE_CYCLES = 2,
    parameter int unsigned GAP_CYCLES   = 2
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       INT,
    input  logic       int_enable,
    input  logic [7:0] data_bus,
    output logic       INTA,
    output logic [7:0] vector,
    output logic       vector_valid,
    input  logic       vector_ack,
    output logic       spurious,
    output logic       busy
);

    localparam logic [7:0] PULSE_LOAD = 8'(PULSE_CYCLES - 1);
    localparam logic [7:0] GAP_LOAD   = 8'(GAP_CYCLES - 1);

    typedef enum logic [2:0] {
        IDLE,
        SYNC,
        PULSE1,
        GAP,
        PULSE2,
        HOLD
    } state_t;

    state_t      state_q, state_d;
    logic [7:0]  cnt_q, cnt_d;
    logic        int_meta_q, int_meta_d;
    logic        int_sync_q, int_sync_d;
    logic        inta_q, inta_d;
    logic [7:0]  vector_q, vector_d;
    logic        valid_q, valid_d;
    logic        busy_q, busy_d;
`ifdef INTA_SPURIOUS_EN
    logic        spur_pend_q, spur_pend_d;
    logic        spurious_q, spurious_d;
`endif

    always_comb begin
        int_meta_d = INT;
        int_sync_d = int_meta_q;
        state_d    = state_q;
        cnt_d      = cnt_q;
        inta_d     = inta_q;
        vector_d   = vector_q;
        valid_d    = valid_q;
`ifdef INTA_SPURIOUS_EN
        spur_pend_d = spur_pend_q;
        spurious_d  = spurious_q;
`endif
        case (state_q)
            IDLE: begin
                if (int_sync_q && int_enable && !valid_q) begin
                    state_d = SYNC;
                end
            end
            SYNC: begin
                if (int_enable && int_sync_q) begin
                    state_d = PULSE1;
                    cnt_d   = PULSE_LOAD;
                    inta_d  = 1'b0;
`ifdef INTA_SPURIOUS_EN
                    spur_pend_d = 1'b0;
`endif
                end
`ifdef INTA_SPURIOUS_EN
                // The PIC answers a vanished request with its IR7 vector; run the cycle anyway.
                else if (int_enable) begin
                    state_d     = PULSE1;
                    cnt_d       = PULSE_LOAD;
                    inta_d      = 1'b0;
                    spur_pend_d = 1'b1;
                end
`endif
                else begin
                    state_d = IDLE;
                end
            end
            PULSE1: begin
                if (cnt_q == 8'd0) begin
                    state_d = GAP;
                    cnt_d   = GAP_LOAD;
                    inta_d  = 1'b1;
                end else begin
                    cnt_d = cnt_q - 8'd1;
                end
            end
            GAP: begin
                if (cnt_q == 8'd0) begin
                    state_d = PULSE2;
                    cnt_d   = PULSE_LOAD;
                    inta_d  = 1'b0;
                end else begin
                    cnt_d = cnt_q - 8'd1;
                end
            end
            PULSE2: begin
                // Vector is sampled on the final clock of the second pulse.
                if (cnt_q == 8'd0) begin
                    state_d  = HOLD;
                    inta_d   = 1'b1;
                    vector_d = data_bus;
                    valid_d  = 1'b1;
`ifdef INTA_SPURIOUS_EN
                    spurious_d = spur_pend_q;
`endif
                end else begin
                    cnt_d = cnt_q - 8'd1;
                end
            end
            HOLD: begin
                if (vector_ack) begin
                    state_d = IDLE;
                    valid_d = 1'b0;
`ifdef INTA_SPURIOUS_EN
                    spurious_d = 1'b0;
`endif
                end
            end
            default: begin
                state_d = IDLE;
                inta_d  = 1'b1;
                valid_d = 1'b0;
            end
        endcase
        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q    <= IDLE;
            cnt_q      <= 8'd0;
            int_meta_q <= 1'b0;
            int_sync_q <= 1'b0;
            inta_q     <= 1'b1;
            vector_q   <= 8'h00;
            valid_q    <= 1'b0;
            busy_q     <= 1'b0;
`ifdef INTA_SPURIOUS_EN
            spur_pend_q <= 1'b0;
            spurious_q  <= 1'b0;
`endif
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            int_meta_q <= int_meta_d;
            int_sync_q <= int_sync_d;
            inta_q     <= inta_d;
            vector_q   <= vector_d;
            valid_q    <= valid_d;
            busy_q     <= busy_d;
`ifdef INTA_SPURIOUS_EN
            spur_pend_q <= spur_pend_d;
            spurious_q  <= spurious_d;
`endif
        end
    end

    assign INTA         = inta_q;
    assign vector       = vector_q;
    assign vector_valid = valid_q;
    assign busy         = busy_q;
`ifdef INTA_SPURIOUS_EN
    assign spurious     = spurious_q;
`else
    assign spurious     = 1'b0;
`endif

endmodule

// File: tb/tb_inta_sequencer.sv
// Directed bench for inta_sequencer: a default instance (P=2,G=2) and a P=1,G=3 instance,
// each with a small PIC model that drives the vector only during the second INTA pulse.
module tb_inta_sequencer;

    logic       clock = 1'b0;
    logic       reset = 1'b1;
    logic [7:0] pic_vec = 8'hA9;

    logic       int1 = 1'b0, en1 = 1'b0, ack1 = 1'b0;
    logic [7:0] data1;
    logic       inta1, vv1, sp1, busy1;
    logic [7:0] vec1;
    logic       pulse_no1 = 1'b0;

    logic       int2 = 1'b0, en2 = 1'b0, ack2 = 1'b0;
    logic [7:0] data2;
    logic       inta2, vv2, sp2, busy2;
    logic [7:0] vec2;
    logic       pulse_no2 = 1'b0;

    typedef struct {
        logic [7:0] vec;
        logic       spur;
    } exp_t;
    exp_t sb[$];

    int n_cmp = 0;
    int n_err = 0;

    always #5 clock = ~clock;

    inta_sequencer #(.PULSE_CYCLES(2), .GAP_CYCLES(2)) dut1 (
        .clock(clock), .reset(reset), .INT(int1), .int_enable(en1), .data_bus(data1),
        .INTA(inta1), .vector(vec1), .vector_valid(vv1), .vector_ack(ack1),
        .spurious(sp1), .busy(busy1)
    );

    inta_sequencer #(.PULSE_CYCLES(1), .GAP_CYCLES(3)) dut2 (
        .clock(clock), .reset(reset), .INT(int2), .int_enable(en2), .data_bus(data2),
        .INTA(inta2), .vector(vec2), .vector_valid(vv2), .vector_ack(ack2),
        .spurious(sp2), .busy(busy2)
    );

    // PIC model: pulse_no toggles at the end of each INTA pulse, so it is 1 during pulse two.
    always @(posedge inta1 or posedge reset) begin
        if (reset) pulse_no1 <= 1'b0;
        else       pulse_no1 <= ~pulse_no1;
    end
    always @(posedge inta2 or posedge reset) begin
        if (reset) pulse_no2 <= 1'b0;
        else       pulse_no2 <= ~pulse_no2;
    end
    assign data1 = (!inta1 && pulse_no1) ? pic_vec : 8'h00;
    assign data2 = (!inta2 && pulse_no2) ? pic_vec : 8'h00;

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic inta_of(input int s);
        return (s == 2) ? inta2 : inta1;
    endfunction

    // Expects INTA to fall after 'lat' ticks, then checks pulse/gap widths and the vector handoff.
    task automatic do_cycle(input string tag, input int s, input int lat, input int p, input int g);
        int   n, lo, hi, lo2;
        exp_t e;
        n = 0;
        while (inta_of(s) === 1'b1 && n < 200) begin tick(); n++; end
        chk({tag, " latency"}, n, lat);
        lo = 0;
        while (inta_of(s) === 1'b0 && lo < 300) begin lo++; tick(); end
        chk({tag, " pulse1"}, lo, p);
        hi = 0;
        while (inta_of(s) === 1'b1 && hi < 300) begin hi++; tick(); end
        chk({tag, " gap"}, hi, g);
        lo2 = 0;
        while (inta_of(s) === 1'b0 && lo2 < 300) begin lo2++; tick(); end
        chk({tag, " pulse2"}, lo2, p);
        chk({tag, " valid"}, (s == 2) ? vv2 : vv1, 1);
        if (sb.size() == 0) begin
            chk({tag, " scoreboard empty"}, 0, 1);
        end else begin
            e = sb.pop_front();
            chk({tag, " vector"}, (s == 2) ? vec2 : vec1, e.vec);
            chk({tag, " spurious"}, (s == 2) ? sp2 : sp1, e.spur);
        end
        $display("cycle %s: lat=%0d low=%0d high=%0d low=%0d vector=%02h", tag, n, lo, hi, lo2,
                 (s == 2) ? vec2 : vec1);
    endtask

    initial begin
        int cnt_lo, cnt_vl;

        // Reset state
        tick(); tick();
        chk("rst INTA", inta1, 1);
        chk("rst vector", vec1, 8'h00);
        chk("rst valid", vv1, 0);
        chk("rst spurious", sp1, 0);
        chk("rst busy", busy1, 0);
        chk("rst INTA2", inta2, 1);
        reset = 1'b0;

        // INT high with interrupts disabled: nothing happens
        int1 = 1'b1;
        cnt_lo = 0; cnt_vl = 0;
        for (int i = 0; i < 50; i++) begin
            tick();
            if (inta1 !== 1'b1) cnt_lo++;
            if (busy1 !== 1'b0) cnt_vl++;
        end
        chk("disabled INTA lows", cnt_lo, 0);
        chk("disabled busy", cnt_vl, 0);

        // Enable rises: cycle starts two edges later
        sb.push_back('{vec: 8'hA9, spur: 1'b0});
        en1 = 1'b1;
        do_cycle("en_rise", 1, 2, 2, 2);

        // Ack withheld with INT still high: no new pulses, vector held
        cnt_lo = 0; cnt_vl = 0;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (inta1 !== 1'b1) cnt_lo++;
            if (vv1 !== 1'b1) cnt_vl++;
        end
        chk("hold INTA lows", cnt_lo, 0);
        chk("hold valid drops", cnt_vl, 0);
        chk("hold vector", vec1, 8'hA9);
        ack1 = 1'b1;
        tick();
        chk("ack clears valid", vv1, 0);
        chk("ack idle busy", busy1, 0);
        ack1 = 1'b0;
        sb.push_back('{vec: 8'hA9, spur: 1'b0});
        do_cycle("re_entry", 1, 2, 2, 2);

        // Ack held high across the next cycle: valid lasts exactly one cycle
        ack1 = 1'b1;
        tick();
        chk("ack2 clears valid", vv1, 0);
        pic_vec = 8'h5C;
        sb.push_back('{vec: 8'h5C, spur: 1'b0});
        do_cycle("ack_early", 1, 2, 2, 2);
        en1 = 1'b0;
        tick();
        chk("one-cycle valid", vv1, 0);
        int1 = 1'b0;
        ack1 = 1'b0;
        for (int i = 0; i < 5; i++) tick();
        chk("quiet busy", busy1, 0);

        // Reset asserted during PULSE2, then a fresh cycle with INT still high
        pic_vec = 8'hA9;
        en1 = 1'b1;
        int1 = 1'b1;
        for (int i = 0; i < 8; i++) tick();
        chk("in PULSE2 INTA", inta1, 0);
        reset = 1'b1;
        #1;
        chk("async rst INTA", inta1, 1);
        chk("async rst valid", vv1, 0);
        chk("async rst busy", busy1, 0);
        tick(); tick();
        reset = 1'b0;
        sb.push_back('{vec: 8'hA9, spur: 1'b0});
        do_cycle("post_reset", 1, 4, 2, 2);
        int1 = 1'b0;
        for (int i = 0; i < 5; i++) tick();
        ack1 = 1'b1;
        tick();
        ack1 = 1'b0;
        chk("post_reset ack", vv1, 0);

        // Short INT pulse that is gone when SYNC confirms
        pic_vec = 8'hAF;
        int1 = 1'b1;
        tick();
        int1 = 1'b0;
`ifdef INTA_SPURIOUS_EN
        sb.push_back('{vec: 8'hAF, spur: 1'b1});
        do_cycle("spurious", 1, 3, 2, 2);
        ack1 = 1'b1;
        tick();
        ack1 = 1'b0;
        chk("spurious clears", sp1, 0);
`else
        cnt_lo = 0;
        for (int i = 0; i < 12; i++) begin
            tick();
            if (inta1 !== 1'b1) cnt_lo++;
        end
        chk("glitch INTA lows", cnt_lo, 0);
        chk("glitch busy", busy1, 0);
        chk("glitch spurious", sp1, 0);
`endif

        // P=1, G=3 instance
        pic_vec = 8'h3C;
        en2 = 1'b1;
        int2 = 1'b1;
        sb.push_back('{vec: 8'h3C, spur: 1'b0});
        do_cycle("p1g3", 2, 4, 1, 3);
        int2 = 1'b0;
        for (int i = 0; i < 4; i++) tick();
        ack2 = 1'b1;
        tick();
        ack2 = 1'b0;
        chk("p1g3 ack", vv2, 0);

        chk("scoreboard drained", sb.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
